// File: rtl/uart_pkt_rx.sv
// UART packet receiver: 8N1 byte receiver feeding a SYNC/ID/payload/checksum deframer.
// Optional UART_PKT_RX_STATS_EN adds stat_clr input and saturating stat_good/stat_err counters.
module uart_pkt_rx #(
    parameter int unsigned CLK_FRE      = 50,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_BYTES   = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_pin,
    output logic [NUM_CH*DATA_BYTES*8-1:0] ch_data,
    output logic [NUM_CH-1:0]              ch_update,
    output logic                           pkt_valid,
    input  logic                           pkt_ready,
    output logic [7:0]                     pkt_ch,
    output logic [DATA_BYTES*8-1:0]        pkt_data,
    output logic                           err_frame,
    output logic                           err_sum,
    output logic                           err_ch,
    output logic                           err_ovf
`ifdef UART_PKT_RX_STATS_EN
    ,
    input  logic                           stat_clr,
    output logic [15:0]                    stat_good,
    output logic [15:0]                    stat_err
`endif
);
    localparam int unsigned W     = DATA_BYTES * 8;
    localparam logic [15:0] CYCLE = 16'(CLK_FRE * 1000000 / BAUD_RATE);
    localparam logic [15:0] HALF  = CYCLE / 16'd2 - 16'd1;
    localparam int unsigned TMO   = TIMEOUT_BITS * 32'(CYCLE);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [1:0] {P_SYNC, P_CH, P_DATA, P_SUM} pstate_t;

    bstate_t      r_bstate, w_bnext;
    pstate_t      r_pstate, w_pnext;
    logic         r_rx_s1, r_rx_s2, r_rx_d;
    logic [15:0]  r_cnt;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;
    logic         r_byte_vld;
    logic [7:0]   r_sum, r_id;
    logic [1:0]   r_idx;
    logic [W-1:0] r_payload;
    logic [31:0]  r_tmo;
    logic         w_mid, w_end, w_last, w_commit, w_id_ok, w_sum_ok;
    logic [7:0]   w_total;

    assign w_mid = (r_cnt == HALF);
    assign w_end = (r_cnt == CYCLE - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate <= B_IDLE;
            r_pstate <= P_SYNC;
        end else begin
            r_bstate <= w_bnext;
            r_pstate <= w_pnext;
        end
    end

    always_comb begin
        w_bnext = r_bstate;
        case (r_bstate)
            B_IDLE:  if (!r_rx_s2 && r_rx_d) w_bnext = B_START;
            B_START: if (w_mid && r_rx_s2) w_bnext = B_IDLE;
                     else if (w_end) w_bnext = B_DATA;
            B_DATA:  if (w_end && r_bit == 3'd7) w_bnext = B_STOP;
            B_STOP:  if (w_mid) w_bnext = B_IDLE;
            default: w_bnext = B_IDLE;
        endcase
    end

    // Stop bit sampled at mid-bit; early return to idle leaves room for back-to-back bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_byte_vld <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            r_rx_s1    <= rx_pin;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_byte_vld <= 1'b0;
            err_frame  <= 1'b0;
            if (r_bstate == B_IDLE || w_end) r_cnt <= '0;
            else                             r_cnt <= r_cnt + 16'd1;
            if (r_bstate == B_IDLE)              r_bit <= '0;
            else if (r_bstate == B_DATA && w_end) r_bit <= r_bit + 3'd1;
            if (r_bstate == B_DATA && w_mid) r_shift <= {r_rx_s2, r_shift[7:1]};
            if (r_bstate == B_STOP && w_mid) begin
                r_byte_vld <= r_rx_s2;
                err_frame  <= !r_rx_s2;
            end
        end
    end

    assign w_total  = r_sum + r_shift;
    assign w_sum_ok = (w_total == 8'h00);
    assign w_id_ok  = (32'(r_id) < NUM_CH);
    assign w_last   = r_byte_vld && (r_pstate == P_SUM);
    assign w_commit = w_last && w_sum_ok && w_id_ok;

    always_comb begin
        w_pnext = r_pstate;
        if (r_byte_vld) begin
            case (r_pstate)
                P_SYNC:  if (r_shift == SYNC_BYTE) w_pnext = P_CH;
                P_CH:    w_pnext = P_DATA;
                P_DATA:  if (r_idx == 2'(DATA_BYTES - 1)) w_pnext = P_SUM;
                P_SUM:   w_pnext = P_SYNC;
                default: w_pnext = P_SYNC;
            endcase
        end else if (r_pstate != P_SYNC && (err_frame || r_tmo == TMO - 1)) begin
            w_pnext = P_SYNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_id      <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            r_tmo     <= '0;
            ch_data   <= '0;
            ch_update <= '0;
            pkt_valid <= 1'b0;
            pkt_ch    <= '0;
            pkt_data  <= '0;
            err_sum   <= 1'b0;
            err_ch    <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            err_sum <= w_last && w_id_ok && !w_sum_ok;
            err_ch  <= w_last && !w_id_ok;
            err_ovf <= w_commit && pkt_valid && !pkt_ready;
            if (r_pstate == P_SYNC || r_byte_vld) r_tmo <= '0;
            else                                  r_tmo <= r_tmo + 32'd1;
            if (r_byte_vld) begin
                case (r_pstate)
                    P_SYNC: r_sum <= '0;
                    P_CH: begin
                        r_id  <= r_shift;
                        r_sum <= r_sum + r_shift;
                        r_idx <= '0;
                    end
                    P_DATA: begin
                        r_payload <= (r_payload << 8) | W'(r_shift);
                        r_sum     <= r_sum + r_shift;
                        r_idx     <= r_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                ch_update[k] <= w_commit && (32'(r_id) == k);
                if (w_commit && 32'(r_id) == k) ch_data[k*W +: W] <= r_payload;
            end
            if (w_commit && (!pkt_valid || pkt_ready)) begin
                pkt_valid <= 1'b1;
                pkt_ch    <= r_id;
                pkt_data  <= r_payload;
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

`ifdef UART_PKT_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good <= '0;
            stat_err  <= '0;
        end else if (stat_clr) begin
            stat_good <= '0;
            stat_err  <= '0;
        end else begin
            if (|ch_update && stat_good != '1) stat_good <= stat_good + 16'd1;
            if ((err_frame || err_sum || err_ch || err_ovf) && stat_err != '1)
                stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: directed packet scenarios plus randomized packets against a
// packet-level reference model (channel array, held-packet slot, event counters).
module tb_uart_pkt_rx;
    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned BIT = 16;

    logic clk = 1'b0, rst_n = 1'b0, rx_pin = 1'b1, pkt_ready = 1'b1;
    logic [NCH*W-1:0] ch_data;
    logic [NCH-1:0]   ch_update;
    logic             pkt_valid;
    logic [7:0]       pkt_ch;
    logic [W-1:0]     pkt_data;
    logic             err_frame, err_sum, err_ch, err_ovf;
`ifdef UART_PKT_RX_STATS_EN
    logic             stat_clr = 1'b0;
    logic [15:0]      stat_good, stat_err;
`endif

    uart_pkt_rx #(
        .CLK_FRE(1), .BAUD_RATE(62500), .NUM_CH(NCH), .DATA_BYTES(2),
        .SYNC_BYTE(8'hAA), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin),
        .ch_data(ch_data), .ch_update(ch_update),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_ch(pkt_ch), .pkt_data(pkt_data),
        .err_frame(err_frame), .err_sum(err_sum), .err_ch(err_ch), .err_ovf(err_ovf)
`ifdef UART_PKT_RX_STATS_EN
        , .stat_clr(stat_clr), .stat_good(stat_good), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0, n_pass = 0;

    int unsigned m_upd = 0, m_sum = 0, m_chr = 0, m_frm = 0, m_ovf = 0, m_xfer = 0;
    logic [NCH-1:0] m_upd_val = '0;
    logic [7:0]     m_xfer_ch = '0;
    logic [W-1:0]   m_xfer_data = '0;

    always @(negedge clk) begin
        if (ch_update != '0) begin m_upd++; m_upd_val = ch_update; end
        if (err_sum)   m_sum++;
        if (err_ch)    m_chr++;
        if (err_frame) m_frm++;
        if (err_ovf)   m_ovf++;
        if (pkt_valid && pkt_ready) begin m_xfer++; m_xfer_ch = pkt_ch; m_xfer_data = pkt_data; end
    end

    logic [W-1:0]   e_chv [NCH];
    int unsigned    e_upd = 0, e_sum = 0, e_chr = 0, e_frm = 0, e_ovf = 0, e_xfer = 0;
    logic [NCH-1:0] e_upd_val = '0;
    logic [7:0]     e_xfer_ch = '0, e_held_ch = '0;
    logic [W-1:0]   e_xfer_data = '0, e_held_data = '0;
    logic           e_held = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [NCH*W-1:0] pack_model();
        logic [NCH*W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*W +: W] = e_chv[k];
        return v;
    endfunction

    task automatic verify(input string tag);
        check({tag, "/ch_data"}, 64'(ch_data), 64'(pack_model()));
        check({tag, "/n_update"}, 64'(m_upd), 64'(e_upd));
        check({tag, "/update_val"}, 64'(m_upd_val), 64'(e_upd_val));
        check({tag, "/n_err_sum"}, 64'(m_sum), 64'(e_sum));
        check({tag, "/n_err_ch"}, 64'(m_chr), 64'(e_chr));
        check({tag, "/n_err_frame"}, 64'(m_frm), 64'(e_frm));
        check({tag, "/n_err_ovf"}, 64'(m_ovf), 64'(e_ovf));
        check({tag, "/n_xfer"}, 64'(m_xfer), 64'(e_xfer));
        check({tag, "/xfer_pkt"}, 64'({m_xfer_ch, m_xfer_data}), 64'({e_xfer_ch, e_xfer_data}));
        check({tag, "/pkt_valid"}, 64'(pkt_valid), 64'(e_held));
        if (e_held) check({tag, "/held_pkt"}, 64'({pkt_ch, pkt_data}), 64'({e_held_ch, e_held_data}));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_pin = frame[i];
            repeat (BIT) @(negedge clk);
        end
        rx_pin = 1'b1;
    endtask

    task automatic model_pkt(input logic [7:0] ch, input logic [W-1:0] d, input logic [7:0] s);
        logic [7:0] tot;
        tot = ch + d[15:8] + d[7:0] + s;
        if (ch >= NCH) e_chr++;
        else if (tot != 8'h00) e_sum++;
        else begin
            e_chv[ch] = d;
            e_upd++;
            e_upd_val = NCH'(1) << ch;
            if (pkt_ready) begin
                e_xfer++; e_xfer_ch = ch; e_xfer_data = d;
            end else if (e_held) e_ovf++;
            else begin
                e_held = 1'b1; e_held_ch = ch; e_held_data = d;
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] ch, input logic [W-1:0] d, input logic [7:0] s,
                            input string tag);
        send_byte(8'hAA, 1'b1);
        send_byte(ch, 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(s, 1'b1);
        repeat (4) @(negedge clk);
        model_pkt(ch, d, s);
        verify(tag);
    endtask

    task automatic set_ready(input logic v);
        pkt_ready = v;
        if (v && e_held) begin
            e_xfer++; e_xfer_ch = e_held_ch; e_xfer_data = e_held_data; e_held = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) e_chv[k] = '0;
        e_held = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]   rch, rs;
        logic [W-1:0] rd;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("reset/outputs", 64'({ch_update, pkt_valid, pkt_ch, pkt_data, err_frame, err_sum, err_ch, err_ovf}), 64'd0);
        verify("reset");

        send_pkt(8'h02, 16'h1234, 8'hB8, "good_ch2");
        send_pkt(8'h01, 16'h0010, 8'h00, "bad_sum");
        send_pkt(8'h01, 16'h0010, 8'hEF, "good_ch1");
        send_pkt(8'h05, 16'h0000, 8'hFB, "bad_ch");

        send_byte(8'hAA, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h56, 1'b1);
        repeat (25 * BIT) @(negedge clk);
        send_pkt(8'h00, 16'hABCD, 8'h88, "after_timeout");

        set_ready(1'b0);
        send_pkt(8'h00, 16'h0001, 8'hFF, "stall_first");
        send_pkt(8'h01, 16'h0002, 8'hFD, "stall_ovf");
        set_ready(1'b1);
        verify("stall_release");

        send_byte(8'hAA, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        rx_pin = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        e_frm++;
        verify("frame_err");
        send_pkt(8'h00, 16'h3456, 8'h76, "after_frame_err");

        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        rx_pin = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("midreset/outputs", 64'({ch_update, pkt_valid, pkt_ch, pkt_data, err_frame, err_sum, err_ch, err_ovf}), 64'd0);
        check("midreset/ch_data", 64'(ch_data), 64'd0);
        rx_pin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_pkt(8'h03, 16'hBEEF, 8'h00 - 8'h03 - 8'hBE - 8'hEF, "after_reset");

        for (int n = 0; n < 20; n++) begin
            set_ready($urandom_range(3) != 0);
            rch = 8'($urandom_range(5));
            rd  = 16'($urandom);
            rs  = 8'h00 - rch - rd[15:8] - rd[7:0];
            if ($urandom_range(3) == 0) rs = rs ^ (8'h01 << $urandom_range(7));
            send_pkt(rch, rd, rs, $sformatf("rnd%0d", n));
        end
        set_ready(1'b1);
        verify("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
